uart_tx_framer: RTL

- Downstream consumer of the UART TX bit-index counter.
- Accepts a data word over a valid/ready handshake and builds the serial frame: start bit, data LSB-first, optional parity, 1 or 2 stop bits.
- Gates baud ticks into the counter's enable and drives the registered tx line from the counter's bit_index.
- Sits between the TX FIFO/host interface and the pin.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_frame_build.sv | 26 ++
 rtl/uart_tx_framer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit framer.
package uart_pkg;

    // Framer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SEND  = 2'd2
    } state_e;

    // Parity modes, selected by the PARITY_ODD parameter.
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Total serial bits per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_width, input int parity_en,
                                      input int stop_bits);
        return 1 + data_width + parity_en + stop_bits;
    endfunction

    // Parity bit from the XOR-reduction of the data word.
    function automatic logic parity_of(input logic data_xor, input int mode);
        case (mode)
            PAR_EVEN: return data_xor;
            PAR_ODD:  return ~data_xor;
            default:  return data_xor;
        endcase
    endfunction

endpackage

// File: rtl/uart_frame_build.sv
// Combinational packing of one data word into a serial frame vector.
// Bit 0 is the start bit; the data follows LSB first, then the optional
// parity bit, then the stop bits (all ones) in the top positions.
module uart_frame_build
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic [DATA_WIDTH-1:0]                                      data_i,
    output logic [frame_bits(DATA_WIDTH, PARITY_EN, STOP_BITS)-1:0]    frame_o
);

    // Start low, data, optional parity; everything above stays high as stop bits.
    always_comb begin
        frame_o                 = '1;
        frame_o[0]              = 1'b0;
        frame_o[DATA_WIDTH:1]   = data_i;
        if (PARITY_EN != 0) begin
            frame_o[DATA_WIDTH+1] = parity_of(^data_i, PARITY_ODD);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word over valid/ready, latches the packed
// frame, gates baud ticks into the external bit-index counter and drives the
// registered serial line from that counter's bit_index.
//
// Handshake: a word transfers on a rising clock edge where tx_valid and
// tx_ready are both high; tx_ready is high exactly while the FSM is IDLE and
// does not depend on tx_valid; tx_data is sampled only on that edge.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic                   baud_tick,
    input  logic [INDEX_WIDTH-1:0] bit_index,
    output logic                   bit_en,
    output logic                   bit_rst,
    output logic                   tx_out,
    output logic                   tx_active,
    output logic                   frame_done,
    output logic                   index_err,
    output state_e                 state_dbg
);

    localparam int FRAME_BITS = frame_bits(DATA_WIDTH, PARITY_EN, STOP_BITS);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d, frame_new;
    logic                  tx_out_q, tx_out_d;
    logic                  bit_rst_q, bit_rst_d;
    logic                  frame_done_q, frame_done_d;
    logic                  index_err_q, index_err_d;
    logic                  accept, idx_bad, last_bit, cur_bit;

    uart_frame_build #(
        .DATA_WIDTH (DATA_WIDTH),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .STOP_BITS  (STOP_BITS)
    ) u_build (
        .data_i  (tx_data),
        .frame_o (frame_new)
    );

    assign accept   = tx_valid && (state_q == IDLE);
    assign idx_bad  = (int'(bit_index) >= FRAME_BITS);
    assign last_bit = (int'(bit_index) == FRAME_BITS - 1);

    // Select the frame bit addressed by the counter; out-of-range reads idle high.
    always_comb begin
        cur_bit = 1'b1;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (bit_index == INDEX_WIDTH'(i)) cur_bit = frame_q[i];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '1;
            tx_out_q     <= 1'b1;
            bit_rst_q    <= 1'b0;
            frame_done_q <= 1'b0;
            index_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            tx_out_q     <= tx_out_d;
            bit_rst_q    <= bit_rst_d;
            frame_done_q <= frame_done_d;
            index_err_q  <= index_err_d;
        end
    end

    // Next-state logic; an out-of-range index aborts the frame back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ALIGN;
            ALIGN:   if (baud_tick) state_d = SEND;
            SEND: begin
                if (idx_bad)                    state_d = IDLE;
                else if (baud_tick && last_bit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: combinational handshake/enable plus next values of registered outputs.
    always_comb begin
        tx_ready     = (state_q == IDLE);
        bit_en       = baud_tick && (state_q == SEND);
        tx_active    = (state_q == ALIGN) || (state_q == SEND);
        frame_d      = frame_q;
        tx_out_d     = tx_out_q;
        bit_rst_d    = 1'b0;
        frame_done_d = 1'b0;
        index_err_d  = index_err_q;
        unique case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (accept) begin
                    frame_d   = frame_new;
                    bit_rst_d = 1'b1;
                end
            end
            // The start bit begins on the baud edge so it spans a full period.
            ALIGN: if (baud_tick) tx_out_d = 1'b0;
            SEND: begin
                if (idx_bad) begin
                    index_err_d = 1'b1;
                    tx_out_d    = 1'b1;
                end else begin
                    tx_out_d = cur_bit;
                    if (baud_tick && last_bit) frame_done_d = 1'b1;
                end
            end
            default: tx_out_d = 1'b1;
        endcase
    end

    assign bit_rst    = bit_rst_q;
    assign tx_out     = tx_out_q;
    assign frame_done = frame_done_q;
    assign index_err  = index_err_q;
    assign state_dbg  = state_q;

endmodule
